// File: rtl/wall_motion_sequencer.sv
`timescale 1ns/1ps
// Motion sequencer between raw robot sensors, the wall-follower FSM and the motors:
// debounces Head/Left, strobes the FSM, runs fixed-length moves with collision abort.
module wall_motion_sequencer #(
    parameter int TICK_DIV  = 4,
    parameter int FWD_STEPS = 3,
    parameter int ROT_STEPS = 2,
    parameter int DEB_LEN   = 2
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic       Head,
    input  logic       Left,
    input  logic       Front_req,
    input  logic       Rotate_req,
    output logic       Head_clean,
    output logic       Left_clean,
    output logic       Fsm_step,
    output logic       Motor_fwd,
    output logic       Motor_rot,
    output logic       Busy,
    output logic       Collision,
    output logic [7:0] Step_count
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, FORWARD, ROTATE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    remaining_q, remaining_d;
    logic [7:0]    step_q, step_d;
    logic [1:0]    clean_q, clean_d;
    logic [2:0]    deb_cnt_q [2];
    logic [2:0]    deb_cnt_d [2];
    logic          motor_fwd_q, motor_rot_q, busy_q, collision_q, collision_d;
    logic          tick, head_rise, fsm_step;
    logic [1:0]    raw;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign raw  = {Left, Head};

    // Index 0 is Head, index 1 is Left; both only advance on a tick.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        clean_d   = clean_q;
        deb_cnt_d = deb_cnt_q;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != clean_q[i]) begin
                    if (deb_cnt_q[i] == 3'(DEB_LEN - 1)) begin
                        clean_d[i]   = raw[i];
                        deb_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + 3'd1;
                    end
                end else begin
                    deb_cnt_d[i] = '0;
                end
            end
        end
    end

    assign head_rise = clean_d[0] & ~clean_q[0];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        step_d      = step_q;
        collision_d = 1'b0;
        fsm_step    = 1'b0;
        tick_cnt_d  = (state_q == IDLE || tick) ? '0 : tick_cnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (Enable) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (tick) begin
                    fsm_step = 1'b1;
                    if (Rotate_req) begin
                        state_d     = ROTATE;
                        remaining_d = 4'(ROT_STEPS);
                    end else if (Front_req) begin
                        state_d     = FORWARD;
                        remaining_d = 4'(FWD_STEPS);
                    end
                end
            end
            FORWARD: begin
                if (tick) begin
                    step_d      = step_q + 8'd1;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) state_d = SAMPLE;
                end
                // The abort overrides a completing tick, but that tick still counts.
                if (head_rise) begin
                    state_d     = ROTATE;
                    remaining_d = 4'(ROT_STEPS);
                    collision_d = 1'b1;
                end
            end
            ROTATE: begin
                if (tick) begin
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) state_d = SAMPLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping Enable also withholds the strobe so the wall-follower never
        // advances on a sample this block is about to discard.
        if (!Enable) begin
            state_d     = IDLE;
            remaining_d = '0;
            tick_cnt_d  = '0;
            collision_d = 1'b0;
            fsm_step    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            remaining_q <= '0;
            step_q      <= '0;
            clean_q     <= '0;
            deb_cnt_q   <= '{default: '0};
            motor_fwd_q <= 1'b0;
            motor_rot_q <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            remaining_q <= remaining_d;
            step_q      <= step_d;
            clean_q     <= clean_d;
            deb_cnt_q   <= deb_cnt_d;
            motor_fwd_q <= (state_d == FORWARD);
            motor_rot_q <= (state_d == ROTATE);
            busy_q      <= (state_d == FORWARD) || (state_d == ROTATE);
            collision_q <= collision_d;
        end
    end

    assign Head_clean = clean_q[0];
    assign Left_clean = clean_q[1];
    assign Fsm_step   = fsm_step;
    assign Motor_fwd  = motor_fwd_q;
    assign Motor_rot  = motor_rot_q;
    assign Busy       = busy_q;
    assign Collision  = collision_q;
    assign Step_count = step_q;

endmodule

// File: tb/tb_wall_motion_sequencer.sv
`timescale 1ns/1ps
// Directed bench for wall_motion_sequencer with default parameters.
// Cycle n is the interval after rising edge n; all checks happen on the falling edge.
module tb_wall_motion_sequencer;

    logic       Clock, Reset_n, Enable, Head, Left, Front_req, Rotate_req;
    logic       Head_clean, Left_clean, Fsm_step, Motor_fwd, Motor_rot, Busy, Collision;
    logic [7:0] Step_count;

    int n_cmp = 0;
    int n_mis = 0;

    wall_motion_sequencer dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .Head       (Head),
        .Left       (Left),
        .Front_req  (Front_req),
        .Rotate_req (Rotate_req),
        .Head_clean (Head_clean),
        .Left_clean (Left_clean),
        .Fsm_step   (Fsm_step),
        .Motor_fwd  (Motor_fwd),
        .Motor_rot  (Motor_rot),
        .Busy       (Busy),
        .Collision  (Collision),
        .Step_count (Step_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        Reset_n = 1'b0; Enable = 1'b0; Head = 1'b0; Left = 1'b0;
        Front_req = 1'b0; Rotate_req = 1'b0;
        cyc(2);
        check("rst_motor_fwd", Motor_fwd, 0);
        check("rst_motor_rot", Motor_rot, 0);
        check("rst_busy", Busy, 0);
        check("rst_collision", Collision, 0);
        check("rst_fsm_step", Fsm_step, 0);
        check("rst_step_count", Step_count, 0);
        check("rst_head_clean", Head_clean, 0);
        check("rst_left_clean", Left_clean, 0);

        // Cycle 0: release reset and request forward.
        Reset_n = 1'b1; Enable = 1'b1; Front_req = 1'b1;
        cyc(3);                                        // cycle 3
        check("fsm_step_c3", Fsm_step, 0);
        cyc(1);                                        // cycle 4
        check("fsm_step_c4", Fsm_step, 1);
        check("motor_fwd_c4", Motor_fwd, 0);
        cyc(1);                                        // cycle 5
        check("motor_fwd_c5", Motor_fwd, 1);
        check("busy_c5", Busy, 1);
        check("fsm_step_c5", Fsm_step, 0);
        cyc(11);                                       // cycle 16
        check("motor_fwd_c16", Motor_fwd, 1);
        check("step_c16", Step_count, 2);
        cyc(1);                                        // cycle 17
        check("motor_fwd_c17", Motor_fwd, 0);
        check("busy_c17", Busy, 0);
        check("step_c17", Step_count, 3);

        // Both requests at the next strobe: rotate wins.
        Rotate_req = 1'b1;
        cyc(3);                                        // cycle 20
        check("fsm_step_c20", Fsm_step, 1);
        cyc(1);                                        // cycle 21
        check("motor_rot_c21", Motor_rot, 1);
        check("motor_fwd_c21", Motor_fwd, 0);
        Front_req = 1'b0; Rotate_req = 1'b0;
        cyc(7);                                        // cycle 28
        check("motor_rot_c28", Motor_rot, 1);
        check("motor_fwd_c28", Motor_fwd, 0);
        cyc(1);                                        // cycle 29
        check("motor_rot_c29", Motor_rot, 0);
        check("step_c29", Step_count, 3);

        // Head glitch for one tick (32) is rejected.
        Head = 1'b1;
        cyc(4);                                        // cycle 33
        Head = 1'b0;
        cyc(4);                                        // cycle 37
        check("head_glitch", Head_clean, 0);
        // Held through ticks 40 and 44: clean rises on the edge after tick 44.
        Head = 1'b1;
        cyc(7);                                        // cycle 44
        check("head_c44", Head_clean, 0);
        cyc(1);                                        // cycle 45
        check("head_c45", Head_clean, 1);
        Head = 1'b0; Left = 1'b1;
        cyc(8);                                        // cycle 53
        check("head_fall_c53", Head_clean, 0);
        check("left_rise_c53", Left_clean, 1);

        // Forward from tick 56; Head raised so clean rises at tick 64 (remaining=2).
        Front_req = 1'b1;
        cyc(4);                                        // cycle 57
        check("motor_fwd_c57", Motor_fwd, 1);
        Front_req = 1'b0; Head = 1'b1;
        cyc(7);                                        // cycle 64
        check("motor_fwd_c64", Motor_fwd, 1);
        check("collision_c64", Collision, 0);
        check("head_c64", Head_clean, 0);
        cyc(1);                                        // cycle 65
        check("collision_c65", Collision, 1);
        check("motor_fwd_c65", Motor_fwd, 0);
        check("motor_rot_c65", Motor_rot, 1);
        check("step_c65", Step_count, 5);
        cyc(1);                                        // cycle 66
        check("collision_c66", Collision, 0);
        cyc(6);                                        // cycle 72
        check("motor_rot_c72", Motor_rot, 1);
        cyc(1);                                        // cycle 73
        check("motor_rot_c73", Motor_rot, 0);
        check("busy_c73", Busy, 0);

        // 83 back-to-back forward requests (16 cycles each) bring the odometer to 254.
        Front_req = 1'b1;
        cyc(1328);                                     // cycle 1401
        check("step_c1401", Step_count, 254);
        cyc(8);                                        // cycle 1409
        check("step_c1409", Step_count, 255);
        Front_req = 1'b0;
        cyc(4);                                        // cycle 1413
        check("step_wrap_c1413", Step_count, 0);
        cyc(4);                                        // cycle 1417
        check("step_c1417", Step_count, 1);
        check("motor_fwd_c1417", Motor_fwd, 0);

        // Rotate from tick 1420, then drop Enable mid-rotation.
        Rotate_req = 1'b1;
        cyc(4);                                        // cycle 1421
        check("motor_rot_c1421", Motor_rot, 1);
        Rotate_req = 1'b0;
        cyc(1);                                        // cycle 1422
        Enable = 1'b0;
        cyc(1);                                        // cycle 1423
        check("motor_rot_en_low", Motor_rot, 0);
        check("busy_en_low", Busy, 0);
        check("step_en_low", Step_count, 1);
        check("head_retained", Head_clean, 1);
        for (int i = 0; i < 8; i++) begin
            check("fsm_step_en_low", Fsm_step, 0);
            cyc(1);
        end                                            // cycle 1431

        // Re-enable, forward from cycle 1436, then asynchronous reset mid-move.
        Enable = 1'b1; Front_req = 1'b1;
        cyc(4);                                        // cycle 1435
        check("fsm_step_c1435", Fsm_step, 1);
        cyc(1);                                        // cycle 1436
        check("motor_fwd_c1436", Motor_fwd, 1);
        cyc(1);                                        // cycle 1437
        #2 Reset_n = 1'b0;
        #1;
        check("async_motor_fwd", Motor_fwd, 0);
        check("async_busy", Busy, 0);
        check("async_step", Step_count, 0);
        check("async_head_clean", Head_clean, 0);
        cyc(2);
        Reset_n = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
